// File: rtl/hub75_pkg.sv
// Shared constants and types for the HUB75 frame RAM arbiter slice.
package hub75_pkg;

  localparam int unsigned DEF_WIDTH     = 64;
  localparam int unsigned DEF_HEIGHT    = 32;
  localparam int unsigned PIXELS        = DEF_WIDTH * DEF_HEIGHT;
  localparam int unsigned PIX_ADDR_BITS = $clog2(PIXELS);
  localparam int unsigned RD_LATENCY    = 2;

  typedef enum logic {
    BANK_A = 1'b0,
    BANK_B = 1'b1
  } bank_t;

endpackage

// File: rtl/hub75_frame_arbiter_pixel_fifo.sv
// Small synchronous FIFO for queued writer pixels; flush wins over pop, a
// push in the flush cycle lands in slot 0.
module pixel_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rp;
  logic [PW-1:0]     wp;

  always_ff @(posedge clk) begin
    if (push) mem[flush ? '0 : wp] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else if (flush) begin
      rp    <= '0;
      wp    <= push ? PW'(1) : '0;
      count <= CW'(push);
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout  = mem[rp];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/hub75_frame_arbiter.sv
// Arbitrates the single-port double-buffered frame RAM between the HUB75 scan
// reader (absolute priority) and the queued SPI pixel writer.
module hub75_frame_arbiter
  import hub75_pkg::*;
#(
  parameter int unsigned BITS_PER_PIXEL = 32,
  parameter int unsigned WIDTH          = DEF_WIDTH,
  parameter int unsigned HEIGHT         = DEF_HEIGHT,
  parameter int unsigned FIFO_DEPTH     = 4,
  localparam int unsigned NPIX          = WIDTH * HEIGHT,
  localparam int unsigned AW            = $clog2(NPIX)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [BITS_PER_PIXEL-1:0] wr_data,
  input  logic                      wr_restart,
  input  logic                      rd_req,
  input  logic [AW-1:0]             rd_addr,
  output logic                      rd_valid,
  output logic [BITS_PER_PIXEL-1:0] rd_data,
  input  logic                      rd_frame_end,
  output logic [AW:0]               mem_addr,
  output logic                      mem_we,
  output logic [BITS_PER_PIXEL-1:0] mem_wdata,
  input  logic [BITS_PER_PIXEL-1:0] mem_rdata,
  output logic                      front_bank,
  output logic                      swap_pending,
  output logic [7:0]                swap_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [BITS_PER_PIXEL-1:0] fifo_head;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [CW-1:0]             fifo_count;
  logic [CW-1:0]             count_next;
  logic                      push;
  logic                      pop;
  logic                      back_bank;
  bank_t                     front_q;
  logic [AW-1:0]             wp;
  logic [RD_LATENCY-1:0]     rd_pipe;

  // wr_ready is registered, so it must look at the occupancy after this edge.
  always_comb begin
    push       = wr_valid && wr_ready && !fifo_full;
    pop        = !rd_req && !fifo_empty && !swap_pending && !wr_restart;
    count_next = fifo_count + CW'(push) - CW'(pop);
    if (wr_restart) count_next = CW'(push);
  end

  assign back_bank  = ~front_q;
  assign front_bank = front_q;

  pixel_fifo #(
    .DATA_W (BITS_PER_PIXEL),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (wr_restart),
    .din   (wr_data),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front_q      <= BANK_A;
      swap_pending <= 1'b0;
      swap_count   <= '0;
      wp           <= '0;
      wr_ready     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      rd_pipe      <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
    end else begin
      wr_ready <= (count_next != CW'(FIFO_DEPTH));

      rd_pipe  <= {rd_pipe[RD_LATENCY-2:0], rd_req};
      rd_valid <= rd_pipe[RD_LATENCY-1];
      if (rd_pipe[RD_LATENCY-1]) rd_data <= mem_rdata;

      if (rd_req) begin
        mem_we   <= 1'b0;
        mem_addr <= {front_q, rd_addr};
      end else if (pop) begin
        mem_we    <= 1'b1;
        mem_addr  <= {back_bank, wp};
        mem_wdata <= fifo_head;
        if (wp == AW'(NPIX - 1)) begin
          wp           <= '0;
          swap_pending <= 1'b1;
        end else begin
          wp <= wp + AW'(1);
        end
      end else begin
        mem_we <= 1'b0;
      end

      if (wr_restart) wp <= '0;

      // A pop needs swap_pending low and a swap needs it high, so these never collide.
      if (rd_frame_end && swap_pending) begin
        front_q      <= bank_t'(back_bank);
        swap_pending <= 1'b0;
        swap_count   <= swap_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hub75_frame_arbiter.sv
// Randomised and directed bench for hub75_frame_arbiter against a queue-based
// reference model of the pixel stream, banks and read pipeline.
module tb_hub75_frame_arbiter;

  localparam int unsigned PIX   = 2048;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [31:0]   wr_data = '0;
  logic          wr_restart = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [31:0]   rd_data;
  logic          rd_frame_end = 1'b0;
  logic [AW:0]   mem_addr;
  logic          mem_we;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;
  logic          front_bank;
  logic          swap_pending;
  logic [7:0]    swap_count;

  bit [31:0] ram [0:2*PIX-1];
  bit [31:0] img [0:2*PIX-1];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [31:0]   q[$];
  rd_exp_t       rq[$];
  bit            m_front, m_pend, exp_we, last_rd, seen_edge;
  int unsigned   m_swaps, cyc, wr_total;
  logic [AW-1:0] m_idx;
  logic [AW:0]   last_rdaddr, last_w_addr;
  logic [31:0]   last_w_data;
  bit            nx_push, nx_restart, nx_rdreq, nx_fe;
  logic [AW-1:0] nx_addr;
  logic [31:0]   nx_data;

  always #5 clk = ~clk;

  hub75_frame_arbiter #(
    .BITS_PER_PIXEL (32),
    .WIDTH          (64),
    .HEIGHT         (32),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_data      (wr_data),
    .wr_restart   (wr_restart),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_frame_end (rd_frame_end),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .front_bank   (front_bank),
    .swap_pending (swap_pending),
    .swap_count   (swap_count)
  );

  // External frame RAM, one cycle read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    rq.delete();
    m_front = 1'b0; m_pend = 1'b0; m_swaps = 0; m_idx = '0;
    exp_we = 1'b0; last_rd = 1'b0; seen_edge = 1'b0;
    nx_push = 1'b0; nx_restart = 1'b0; nx_rdreq = 1'b0; nx_fe = 1'b0;
    nx_addr = '0; nx_data = '0;
  endtask

  // Apply the inputs sampled at the previous falling edge to the model.
  task automatic on_posedge();
    cyc++;
    seen_edge   = 1'b1;
    exp_we      = !nx_rdreq && !nx_restart && (q.size() > 0) && !m_pend;
    last_rd     = nx_rdreq;
    last_rdaddr = {m_front, nx_addr};
    if (nx_rdreq) rq.push_back('{cyc + 2, img[{m_front, nx_addr}]});
    if (nx_fe && m_pend) begin
      m_front = ~m_front;
      m_pend  = 1'b0;
      m_swaps++;
    end
    if (nx_restart) begin
      q.delete();
      m_idx = '0;
    end
    if (nx_push) q.push_back(nx_data);
  endtask

  task automatic on_negedge();
    logic [31:0] d;
    bit expv;
    check("mem_we", 64'(mem_we), 64'(exp_we));
    if (mem_we && exp_we && q.size() > 0) begin
      d = q.pop_front();
      check("wr_addr", 64'(mem_addr), 64'({~m_front, m_idx}));
      check("wr_data", 64'(mem_wdata), 64'(d));
      img[{~m_front, m_idx}] = d;
      wr_total++;
      last_w_addr = mem_addr;
      last_w_data = mem_wdata;
      if (m_idx == AW'(PIX - 1)) begin
        m_idx  = '0;
        m_pend = 1'b1;
      end else begin
        m_idx = m_idx + AW'(1);
      end
    end
    if (last_rd) check("rd_addr", 64'(mem_addr), 64'(last_rdaddr));
    while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
    expv = (rq.size() > 0) && (rq[0].due == cyc);
    if (expv || rd_valid) check("rd_valid", 64'(rd_valid), 64'(expv));
    if (expv) begin
      check("rd_data", 64'(rd_data), 64'(rq[0].data));
      void'(rq.pop_front());
    end
    check("front_bank", 64'(front_bank), 64'(m_front));
    check("swap_pending", 64'(swap_pending), 64'(m_pend));
    check("swap_count", 64'(swap_count), 64'(m_swaps[7:0]));
    if (seen_edge) check("wr_ready", 64'(wr_ready), 64'(q.size() < DEPTH));
    check("fifo_bound", 64'(q.size() <= DEPTH), 64'(1));
    nx_push    = wr_valid && wr_ready;
    nx_restart = wr_restart;
    nx_rdreq   = rd_req;
    nx_fe      = rd_frame_end;
    nx_addr    = rd_addr;
    nx_data    = wr_data;
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or negedge clk or posedge rst);
      if (rst)      model_clear();
      else if (clk) on_posedge();
      else          on_negedge();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int unsigned n, input bit fixed, input logic [31:0] val);
    int unsigned acc = 0;
    int unsigned guard = 0;
    while (acc < n && guard < 20000) begin
      wr_valid = 1'b1;
      wr_data  = fixed ? val : $urandom;
      if (wr_ready) acc++;
      tick();
      guard++;
    end
    wr_valid = 1'b0;
    check("push_accepted", 64'(acc), 64'(n));
  endtask

  initial begin
    int unsigned w0, s0, acc;
    cyc = 0;
    wr_total = 0;
    model_clear();
    fork
      model_loop();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("rst_front", 64'(front_bank), 64'(0));
    check("rst_pending", 64'(swap_pending), 64'(0));
    check("rst_count", 64'(swap_count), 64'(0));
    check("rst_we", 64'(mem_we), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_rd_valid", 64'(rd_valid), 64'(0));
    check("rst_wr_ready", 64'(wr_ready), 64'(1));

    // Full frame into the back bank.
    w0 = wr_total;
    push_n(PIX, 1'b1, 32'hA0A0A000);
    repeat (8) tick();
    check("t1_writes", 64'(wr_total - w0), 64'(PIX));
    check("t1_last_addr", 64'(last_w_addr), 64'(12'hFFF));
    check("t1_pending", 64'(swap_pending), 64'(1));
    check("t1_front", 64'(front_bank), 64'(0));

    // Swap, then a single read through the pipeline.
    rd_frame_end = 1'b1;
    tick();
    rd_frame_end = 1'b0;
    check("t2_front", 64'(front_bank), 64'(1));
    check("t2_pending", 64'(swap_pending), 64'(0));
    check("t2_count", 64'(swap_count), 64'(1));
    rd_req  = 1'b1;
    rd_addr = AW'(5);
    tick();
    rd_req = 1'b0;
    check("t2_mem_addr", 64'(mem_addr), 64'(12'h805));
    check("t2_valid_n1", 64'(rd_valid), 64'(0));
    tick();
    check("t2_valid_n2", 64'(rd_valid), 64'(0));
    tick();
    check("t2_valid_n3", 64'(rd_valid), 64'(1));
    check("t2_data", 64'(rd_data), 64'(32'hA0A0A000));

    // Reader starves the writer.
    w0  = wr_total;
    acc = 0;
    rd_req   = 1'b1;
    wr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rd_addr = AW'($urandom_range(0, PIX - 1));
      wr_data = $urandom;
      if (wr_ready) acc++;
      tick();
    end
    rd_req   = 1'b0;
    wr_valid = 1'b0;
    check("t3_no_writes", 64'(wr_total - w0), 64'(0));
    check("t3_accepted", 64'(acc), 64'(DEPTH));
    check("t3_ready_low", 64'(wr_ready), 64'(0));
    repeat (10) tick();
    check("t3_resumed", 64'(wr_total - w0), 64'(DEPTH));

    // Frame completes while rd_frame_end is held: swap lands one cycle later.
    s0 = swap_count;
    rd_frame_end = 1'b1;
    push_n(PIX - DEPTH, 1'b0, '0);
    repeat (6) tick();
    rd_frame_end = 1'b0;
    check("t4_one_swap", 64'(swap_count), 64'((s0 + 1) % 256));
    check("t4_front", 64'(front_bank), 64'(0));

    // Restart mid-stream; the restart-cycle pixel becomes pixel 0.
    w0 = wr_total;
    push_n(10, 1'b0, '0);
    check("t5_ready", 64'(wr_ready), 64'(1));
    wr_valid   = 1'b1;
    wr_data    = 32'h11223344;
    wr_restart = 1'b1;
    tick();
    wr_valid   = 1'b0;
    wr_restart = 1'b0;
    repeat (6) tick();
    check("t5_addr", 64'(last_w_addr), 64'(12'h800));
    check("t5_data", 64'(last_w_data), 64'(32'h11223344));
    check("t5_writes", 64'(wr_total - w0), 64'(10));

    // Asynchronous reset with a pending swap and three queued pixels.
    push_n(PIX - 1 + 3, 1'b0, '0);
    tick();
    check("t6_pending", 64'(swap_pending), 64'(1));
    w0 = wr_total;
    #2 rst = 1'b1;
    #1;
    check("t6_front", 64'(front_bank), 64'(0));
    check("t6_pending_rst", 64'(swap_pending), 64'(0));
    check("t6_count", 64'(swap_count), 64'(0));
    check("t6_we", 64'(mem_we), 64'(0));
    check("t6_addr", 64'(mem_addr), 64'(0));
    check("t6_wdata", 64'(mem_wdata), 64'(0));
    check("t6_rd_valid", 64'(rd_valid), 64'(0));
    check("t6_rd_data", 64'(rd_data), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) tick();
    check("t6_no_writes", 64'(wr_total - w0), 64'(0));
    check("t6_ready", 64'(wr_ready), 64'(1));

    // Random traffic against the model.
    for (int i = 0; i < 8000; i++) begin
      wr_valid     = ($urandom_range(0, 9) < 7);
      wr_data      = $urandom;
      rd_req       = ($urandom_range(0, 3) == 0);
      rd_addr      = AW'($urandom_range(0, PIX - 1));
      rd_frame_end = ($urandom_range(0, 49) == 0);
      wr_restart   = ($urandom_range(0, 2999) == 0);
      tick();
    end
    wr_valid = 1'b0; rd_req = 1'b0; rd_frame_end = 1'b0; wr_restart = 1'b0;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_frame_arbiter.md
Name: hub75_frame_arbiter

Overview:
- Shares one single-port pixel RAM between two requesters:
  - the SPI pixel writer, which streams pixels into the back bank;
  - the HUB75 scan reader, which fetches from the front bank.
- The RAM holds two banks of WIDTH*HEIGHT pixels.
- The reader has absolute priority. Writer pixels queue in a small FIFO.
- Banks swap only at a display frame boundary, once a complete back frame exists, so the panel never shows tearing.
- Sits between the SPI pixel assembler, the scan/BCM sequencer and the frame RAM inside the controller top level.

Parameters:
- BITS_PER_PIXEL, 32, pixel word width (RGB0, BITS_PER_PIXEL/4 per channel).
- WIDTH, 64, panel columns.
- HEIGHT, 32, panel rows.
- FIFO_DEPTH, 4, writer queue depth (power of two, at least 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  writer pixel valid.
- wr_ready  out  1  writer may push this cycle.
- wr_data  in  BITS_PER_PIXEL  pixel, raster order from (0,0).
- wr_restart  in  1  pulse: restart the back frame at pixel 0 (SPI select asserted).
- rd_req  in  1  scan reader fetch request.
- rd_addr  in  log2(WIDTH*HEIGHT)  pixel index within the front bank.
- rd_valid  out  1  rd_data valid.
- rd_data  out  BITS_PER_PIXEL  fetched pixel.
- rd_frame_end  in  1  pulse: scanner finished a full modulation frame.
- mem_addr  out  log2(WIDTH*HEIGHT)+1  {bank, index} to RAM.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  BITS_PER_PIXEL  RAM write data.
- mem_rdata  in  BITS_PER_PIXEL  RAM read data, 1-cycle latency after mem_addr.
- front_bank  out  1  bank currently displayed.
- swap_pending  out  1  complete back frame waiting for swap.
- swap_count  out  8  number of completed swaps, wraps modulo 256.

Behaviour:
- Reset values:
  - front_bank=0, swap_pending=0, swap_count=0.
  - FIFO empty, write pointer wp=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - rd_valid=0, rd_data=0.
  - wr_ready=1 one cycle after reset deassertion.
- Reset mid-operation:
  - Aborts everything immediately; queued pixels are lost.
  - The RAM contents are untouched.
- FIFO push and wr_ready:
  - A push happens when wr_valid && wr_ready.
  - wr_ready is a registered !full, where full accounts for a same-cycle pop.
  - A push while full is impossible by construction; the bench asserts it never occurs.
- Per-cycle RAM port decision (mem_* registered, so driven on the next edge):
  - rd_req=1: read at {front_bank, rd_addr}, mem_we=0. Any FIFO pop is stalled that cycle.
  - Otherwise, if the FIFO is non-empty and swap_pending=0: pop, drive mem_we=1, mem_addr={~front_bank, wp}, mem_wdata=head; then wp++.
  - Otherwise: mem_we=0.
- Read latency: rd_req sampled at edge N → mem_addr driven after N → rd_valid=1 and rd_data=mem_rdata (registered) after edge N+2. Fixed latency of 2; back-to-back requests are fully pipelined.
- Frame completion:
  - When a write commits wp=WIDTH*HEIGHT-1, wp wraps to 0 and swap_pending is set on the same edge.
  - While swap_pending=1, pops are blocked. Pushes continue until the FIFO is full, then wr_ready drops (writer back-pressure).
- Swap:
  - Occurs when rd_frame_end=1 and swap_pending=1 at the same edge.
  - front_bank toggles, swap_pending clears, swap_count++.
  - A write that completes the frame in the same cycle as rd_frame_end does NOT swap that cycle; the swap waits for the next rd_frame_end.
  - rd_frame_end with swap_pending=0: no effect (the same frame is redisplayed).
- wr_restart:
  - Flushes the FIFO and sets wp=0. Does not change swap_pending or front_bank.
  - If the same cycle also has a push, the restart is applied first and the pushed pixel becomes pixel 0.
  - If the same cycle has a pop, that pop is suppressed.
- Starvation: a continuous rd_req stream starves the writer indefinitely. This is intended, because display timing dominates.

Decomposition:
- Shared package hub75_pkg holds:
  - PIXELS = WIDTH*HEIGHT;
  - PIX_ADDR_BITS = log2(PIXELS);
  - bank select encoding (BANK_A=0, BANK_B=1);
  - read latency constant RD_LATENCY=2.
- One sub-module, pixel_fifo: synchronous FIFO, parameterised width/depth, push/pop/flush, full/empty/count.

Test Plan:
- Reset, then push 2048 pixels of value 0xA0A0A000 with rd_req=0 → 2048 writes to bank 1 (mem_addr 0x800–0xFFF), swap_pending=1 after the last write, front_bank=0.
- With swap_pending=1, pulse rd_frame_end → front_bank=1, swap_pending=0, swap_count=1. A following rd_req with rd_addr=5 gives mem_addr=0x805, and rd_valid high exactly 2 cycles later.
- rd_req held high for 100 cycles while the writer pushes continuously → zero mem_we pulses, wr_ready=0 after 4 accepted pixels; on rd_req release, writes resume in order.
- Final frame write and rd_frame_end in the same cycle → no swap; the next rd_frame_end swaps, swap_count increments by 1.
- Push 10 pixels, assert wr_restart while pushing pixel 0x11223344 → FIFO flushed, next write lands at index 0 with data 0x11223344.
- Assert reset while the FIFO holds 3 pixels and swap_pending=1 → all outputs return to reset values asynchronously, and no mem_we occurs after release without a new push.
